// File: rtl/mem_result_collector_if.sv
// Bundle between the memristor controller/array and the result collector.
// The slave modport is the collector's view; the master modport is the environment's view.
interface mem_result_collector_if #(
   parameter int DATA_W = 32
);
   logic              issue_valid;
   logic [6:0]        issue_opcode;
   logic [4:0]        issue_rd;
   logic              issue_step;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] buffer_data;
   logic              wb_valid;
   logic [4:0]        wb_rd;
   logic [DATA_W-1:0] wb_data;
   logic              wb_ready;
   logic              stall_req;
   logic              overflow_err;

   modport master (
      output issue_valid, issue_opcode, issue_rd, issue_step, mem_data, wb_ready,
      input  buffer_data, wb_valid, wb_rd, wb_data, stall_req, overflow_err
   );

   modport slave (
      input  issue_valid, issue_opcode, issue_rd, issue_step, mem_data, wb_ready,
      output buffer_data, wb_valid, wb_rd, wb_data, stall_req, overflow_err
   );
endinterface

// File: rtl/mem_result_collector.sv
// Captures the memristor array result one cycle after issue and routes it either back to the
// controller buffer (gate-to-memory ops) or into a tagged FIFO toward CPU register writeback.
module mem_result_collector #(
   parameter int         DEPTH     = 4,
   parameter int         PTR_W     = 2,
   parameter int         DATA_W    = 32,
   parameter logic [6:0] OP_MLW    = 7'h0B,
   parameter logic [6:0] OP_MOR    = 7'h10,
   parameter logic [6:0] OP_MXNOR  = 7'h15,
   parameter logic [6:0] OP_MORM   = 7'h18,
   parameter logic [6:0] OP_MXNORM = 7'h1D
) (
   input logic                  clk,
   input logic                  rst,
   mem_result_collector_if.slave bus
);

   typedef enum logic {
      CLS_CPU = 1'b0,
      CLS_MEM = 1'b1
   } res_class_e;

   typedef struct packed {
      logic [4:0]        rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W+1:0] STALL_AT = (PTR_W+2)'(DEPTH-1);

   logic       is_cpu;
   logic       is_mem;
   logic       capture;
   logic       s1_valid;
   res_class_e s1_class;
   logic [4:0] s1_rd;

   logic [DATA_W-1:0] buf_reg;
   wb_entry_t         fifo_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic              overflow_q;

   logic mem_hit;
   logic cpu_inflight;
   logic push_req;
   logic push_ok;
   logic pop;
   logic full;
   logic [PTR_W+1:0] occupancy;
   wb_entry_t        head;

   assign is_cpu  = (bus.issue_opcode == OP_MLW) ||
                    ((bus.issue_opcode >= OP_MOR) && (bus.issue_opcode <= OP_MXNOR));
   assign is_mem  = (bus.issue_opcode >= OP_MORM) && (bus.issue_opcode <= OP_MXNORM);
   assign capture = bus.issue_valid && (is_cpu || is_mem) && !bus.issue_step;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) s1_valid <= 1'b0;
      else     s1_valid <= capture;
   end

   // Tag fields are qualified by s1_valid, so they need no reset.
   always_ff @(posedge clk) begin
      s1_class <= is_cpu ? CLS_CPU : CLS_MEM;
      s1_rd    <= bus.issue_rd;
   end

   assign mem_hit      = s1_valid && (s1_class == CLS_MEM);
   assign cpu_inflight = s1_valid && (s1_class == CLS_CPU);
   assign push_req     = cpu_inflight && (s1_rd != 5'd0);
   assign full         = (count == FULL_CNT);
   assign pop          = bus.wb_valid && bus.wb_ready;
   assign push_ok      = push_req && (!full || pop);

   always_ff @(posedge clk) begin
      if (rst)          buf_reg <= '0;
      else if (mem_hit) buf_reg <= bus.mem_data;
   end

   // NOTE: FIFO storage is deliberately not reset; pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= '{rd: s1_rd, data: bus.mem_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
         // NOTE: the default arm keeps the case complete, so no unintended hold logic appears.
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (push_req && full && !pop) overflow_q <= 1'b1;
      end
   end

   // Room is reserved for the capture in stage 1 plus the one the controller is issuing now.
   assign occupancy = {1'b0, count} + {{(PTR_W+1){1'b0}}, cpu_inflight};

   assign head             = fifo_mem[rd_ptr];
   assign bus.buffer_data  = mem_hit ? bus.mem_data : buf_reg;
   assign bus.wb_valid     = (count != '0);
   assign bus.wb_rd        = head.rd;
   assign bus.wb_data      = head.data;
   assign bus.stall_req    = (occupancy >= STALL_AT);
   assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_mem_result_collector.sv
// Self-checking bench for mem_result_collector: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_mem_result_collector;

   localparam logic [6:0] MLW   = 7'h0B;
   localparam logic [6:0] MOR   = 7'h10;
   localparam logic [6:0] MAND  = 7'h11;
   localparam logic [6:0] MXOR  = 7'h12;
   localparam logic [6:0] MORM  = 7'h18;
   localparam logic [6:0] MANDM = 7'h19;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   mem_result_collector_if #(.DATA_W(32)) bus ();

   mem_result_collector #(.DEPTH(4), .PTR_W(2), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                        input logic step, input logic [31:0] md, input logic rdy);
      bus.issue_valid  = v;
      bus.issue_opcode = op;
      bus.issue_rd     = rd;
      bus.issue_step   = step;
      bus.mem_data     = md;
      bus.wb_ready     = rdy;
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1;
      drive(1'b0, 7'h0, 5'd0, 1'b0, 32'h0, 1'b0);
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 7'h0, 5'd0, 1'b0, 32'h0, 1'b1);
      tick();
      tick();
      settle();
      n_vec++; if (bus.buffer_data !== 32'h0) begin n_err++; $display("FAIL reset_buffer: got %h want 0", bus.buffer_data); end
      n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid: got %b want 0", bus.wb_valid); end
      n_vec++; if (bus.stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.stall_req); end
      n_vec++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", bus.overflow_err); end
      rst = 1'b0;
   endtask

   task automatic test_mlw();
      tick(); drive(1'b1, MLW, 5'd5, 1'b0, 32'h0, 1'b1); settle();
      tick(); drive(1'b0, 7'h0, 5'd0, 1'b0, 32'hDEADBEEF, 1'b1); settle();
      n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL mlw_early_valid: got %b want 0", bus.wb_valid); end
      n_vec++; if (bus.stall_req !== 1'b0) begin n_err++; $display("FAIL mlw_stall: got %b want 0", bus.stall_req); end
      tick(); drive(1'b0, 7'h0, 5'd0, 1'b0, 32'h0BAD0BAD, 1'b1); settle();
      n_vec++; if (bus.wb_valid !== 1'b1) begin n_err++; $display("FAIL mlw_valid: got %b want 1", bus.wb_valid); end
      n_vec++; if (bus.wb_rd !== 5'd5) begin n_err++; $display("FAIL mlw_rd: got %0d want 5", bus.wb_rd); end
      n_vec++; if (bus.wb_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL mlw_data: got %h want deadbeef", bus.wb_data); end
      tick(); settle();
      n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL mlw_drained: got %b want 0", bus.wb_valid); end
   endtask

   task automatic test_mem_path();
      tick(); drive(1'b1, MANDM, 5'd3, 1'b0, 32'h0, 1'b1); settle();
      tick(); drive(1'b1, MANDM, 5'd3, 1'b1, 32'h0000F0F0, 1'b1); settle();
      n_vec++; if (bus.buffer_data !== 32'h0000F0F0) begin n_err++; $display("FAIL mem_bypass: got %h want 0000f0f0", bus.buffer_data); end
      n_vec++; if (bus.stall_req !== 1'b0) begin n_err++; $display("FAIL mem_stall: got %b want 0", bus.stall_req); end
      tick(); drive(1'b0, 7'h0, 5'd0, 1'b0, 32'h12345678, 1'b1); settle();
      n_vec++; if (bus.buffer_data !== 32'h0000F0F0) begin n_err++; $display("FAIL mem_hold: got %h want 0000f0f0", bus.buffer_data); end
      n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL mem_no_push: got %b want 0", bus.wb_valid); end
      tick(); settle();
      n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL mem_step1_no_push: got %b want 0", bus.wb_valid); end
      n_vec++; if (bus.buffer_data !== 32'h0000F0F0) begin n_err++; $display("FAIL mem_hold2: got %h want 0000f0f0", bus.buffer_data); end
   endtask

   task automatic test_backpressure();
      logic exp_stall [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic exp_dstall [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < 6; k++) begin
         tick();
         drive(k < 4, MOR, 5'(k + 1), 1'b0, (k >= 1 && k <= 4) ? 32'(32'h11 * k) : 32'h0, 1'b0);
         settle();
         n_vec++;
         if (bus.stall_req !== exp_stall[k]) begin
            n_err++; $display("FAIL bp_stall[%0d]: got %b want %b", k, bus.stall_req, exp_stall[k]);
         end
      end
      for (int j = 0; j < 5; j++) begin
         tick(); drive(1'b0, 7'h0, 5'd0, 1'b0, 32'h0, 1'b1); settle();
         n_vec++;
         if (bus.stall_req !== exp_dstall[j]) begin
            n_err++; $display("FAIL bp_drain_stall[%0d]: got %b want %b", j, bus.stall_req, exp_dstall[j]);
         end
         n_vec++;
         if (bus.wb_valid !== (j < 4)) begin
            n_err++; $display("FAIL bp_drain_valid[%0d]: got %b want %b", j, bus.wb_valid, j < 4);
         end else if (j < 4) begin
            n_vec++;
            if (bus.wb_rd !== 5'(j + 1) || bus.wb_data !== 32'(32'h11 * (j + 1))) begin
               n_err++; $display("FAIL bp_drain_entry[%0d]: got %0d/%h want %0d/%h", j, bus.wb_rd, bus.wb_data, j + 1, 32'h11 * (j + 1));
            end
         end
      end
      n_vec++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL bp_overflow: got %b want 0", bus.overflow_err); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int k = 0; k < 7; k++) begin
         tick();
         drive(k < 5, MAND, 5'(k + 1), 1'b0, (k >= 1 && k <= 5) ? 32'(32'h11 * k) : 32'h0, 1'b0);
         settle();
         n_vec++;
         if (bus.overflow_err !== (k == 6)) begin
            n_err++; $display("FAIL ovf_flag[%0d]: got %b want %b", k, bus.overflow_err, k == 6);
         end
      end
      n_vec++;
      if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd1 || bus.wb_data !== 32'h11) begin
         n_err++; $display("FAIL ovf_head: got %b %0d/%h want 1 1/00000011", bus.wb_valid, bus.wb_rd, bus.wb_data);
      end
      for (int j = 0; j < 5; j++) begin
         tick(); drive(1'b0, 7'h0, 5'd0, 1'b0, 32'h0, 1'b1); settle();
         n_vec++;
         if (bus.wb_valid !== (j < 4)) begin
            n_err++; $display("FAIL ovf_drain_valid[%0d]: got %b want %b", j, bus.wb_valid, j < 4);
         end else if (j < 4) begin
            n_vec++;
            if (bus.wb_rd !== 5'(j + 1)) begin
               n_err++; $display("FAIL ovf_drain_rd[%0d]: got %0d want %0d", j, bus.wb_rd, j + 1);
            end
         end
      end
      n_vec++; if (bus.overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow_err); end
      do_reset(); settle();
      n_vec++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL ovf_cleared: got %b want 0", bus.overflow_err); end
   endtask

   task automatic test_back_to_back_full();
      logic [4:0]  exp_rd   [4] = '{5'd2, 5'd3, 5'd4, 5'd7};
      logic [31:0] exp_data [4] = '{32'h22, 32'h33, 32'h44, 32'h77};
      do_reset();
      for (int k = 0; k < 6; k++) begin
         tick();
         drive(k < 5, MOR, (k < 4) ? 5'(k + 1) : 5'd7, 1'b0,
               (k >= 1 && k <= 4) ? 32'(32'h11 * k) : ((k == 5) ? 32'h77 : 32'h0), k == 5);
         settle();
      end
      n_vec++;
      if (bus.wb_rd !== 5'd1 || bus.stall_req !== 1'b1) begin
         n_err++; $display("FAIL full_pp_head: got rd %0d stall %b want rd 1 stall 1", bus.wb_rd, bus.stall_req);
      end
      for (int j = 0; j < 5; j++) begin
         tick(); drive(1'b0, 7'h0, 5'd0, 1'b0, 32'h0, 1'b1); settle();
         n_vec++;
         if (bus.wb_valid !== (j < 4)) begin
            n_err++; $display("FAIL full_pp_valid[%0d]: got %b want %b", j, bus.wb_valid, j < 4);
         end else if (j < 4) begin
            n_vec++;
            if (bus.wb_rd !== exp_rd[j] || bus.wb_data !== exp_data[j]) begin
               n_err++; $display("FAIL full_pp_entry[%0d]: got %0d/%h want %0d/%h", j, bus.wb_rd, bus.wb_data, exp_rd[j], exp_data[j]);
            end
         end
      end
      n_vec++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL full_pp_overflow: got %b want 0", bus.overflow_err); end
   endtask

   task automatic test_rd0_and_reset();
      do_reset();
      tick(); drive(1'b1, MXOR, 5'd0, 1'b0, 32'h0, 1'b1); settle();
      tick(); drive(1'b0, 7'h0, 5'd0, 1'b0, 32'hAAAAAAAA, 1'b1); settle();
      for (int j = 0; j < 2; j++) begin
         tick(); drive(1'b0, 7'h0, 5'd0, 1'b0, 32'h0, 1'b1); settle();
         n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL rd0_valid[%0d]: got %b want 0", j, bus.wb_valid); end
      end
      tick(); drive(1'b1, MORM, 5'd2, 1'b0, 32'h0, 1'b1); settle();
      tick(); drive(1'b0, 7'h0, 5'd0, 1'b0, 32'h5555, 1'b1); settle();
      tick(); drive(1'b1, MOR, 5'd9, 1'b0, 32'h0, 1'b1); settle();
      n_vec++; if (bus.buffer_data !== 32'h5555) begin n_err++; $display("FAIL rst_pre_buffer: got %h want 00005555", bus.buffer_data); end
      tick(); drive(1'b0, 7'h0, 5'd0, 1'b0, 32'hCAFE, 1'b1); rst = 1'b1; settle();
      tick(); rst = 1'b0; drive(1'b0, 7'h0, 5'd0, 1'b0, 32'h0, 1'b1); settle();
      n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL rst_late_push: got %b want 0", bus.wb_valid); end
      n_vec++; if (bus.buffer_data !== 32'h0) begin n_err++; $display("FAIL rst_buffer: got %h want 0", bus.buffer_data); end
      n_vec++; if (bus.stall_req !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", bus.stall_req); end
      tick(); settle();
      n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL rst_late_push2: got %b want 0", bus.wb_valid); end
   endtask

   function automatic bit op_is_cpu(input logic [6:0] op);
      return (op == MLW) || (op >= 7'h10 && op <= 7'h15);
   endfunction

   function automatic bit op_is_mem(input logic [6:0] op);
      return op >= 7'h18 && op <= 7'h1D;
   endfunction

   task automatic test_random();
      logic [6:0]  ops [16] = '{7'h0B, 7'h10, 7'h11, 7'h12, 7'h13, 7'h14, 7'h15, 7'h18,
                                7'h19, 7'h1A, 7'h1B, 7'h1C, 7'h1D, 7'h33, 7'h03, 7'h16};
      logic [4:0]  q_rd [$];
      logic [31:0] q_data [$];
      bit          pend_v = 0, pend_cpu = 0, ovf_m = 0;
      logic [4:0]  pend_rd = '0;
      logic [31:0] buf_m = '0;
      logic        v, step, rdy, exp_stall, pop, push;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [31:0] md, exp_buf;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         tick();
         exp_stall = (q_rd.size() + int'(pend_v && pend_cpu)) >= 3;
         v    = ($urandom_range(0, 3) != 0) && !(exp_stall && $urandom_range(0, 9) != 0);
         op   = ops[$urandom_range(0, 15)];
         rd   = 5'($urandom_range(0, 7));
         step = ($urandom_range(0, 4) == 0);
         md   = $urandom;
         rdy  = ($urandom_range(0, 2) != 0);
         drive(v, op, rd, step, md, rdy);
         settle();
         exp_buf = (pend_v && !pend_cpu) ? md : buf_m;
         n_vec++;
         if (bus.buffer_data !== exp_buf) begin
            n_err++; $display("FAIL rnd_buffer[%0d]: got %h want %h", i, bus.buffer_data, exp_buf);
         end
         n_vec++;
         if (bus.stall_req !== exp_stall) begin
            n_err++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, bus.stall_req, exp_stall);
         end
         n_vec++;
         if (bus.overflow_err !== ovf_m) begin
            n_err++; $display("FAIL rnd_overflow[%0d]: got %b want %b", i, bus.overflow_err, ovf_m);
         end
         n_vec++;
         if (bus.wb_valid !== (q_rd.size() != 0)) begin
            n_err++; $display("FAIL rnd_wb_valid[%0d]: got %b want %b", i, bus.wb_valid, q_rd.size() != 0);
         end else if (q_rd.size() != 0) begin
            n_vec++;
            if (bus.wb_rd !== q_rd[0] || bus.wb_data !== q_data[0]) begin
               n_err++; $display("FAIL rnd_head[%0d]: got %0d/%h want %0d/%h", i, bus.wb_rd, bus.wb_data, q_rd[0], q_data[0]);
            end
         end
         // Advance the reference model across the coming clock edge.
         pop  = (q_rd.size() != 0) && rdy;
         push = pend_v && pend_cpu && (pend_rd != 5'd0);
         if (pend_v && !pend_cpu) buf_m = md;
         if (push && q_rd.size() == 4 && !pop) begin
            ovf_m = 1;
         end else begin
            if (pop) begin void'(q_rd.pop_front()); void'(q_data.pop_front()); end
            if (push) begin q_rd.push_back(pend_rd); q_data.push_back(md); end
         end
         pend_v   = v && (op_is_cpu(op) || op_is_mem(op)) && !step;
         pend_cpu = op_is_cpu(op);
         pend_rd  = rd;
      end
   endtask

   initial begin
      test_reset();
      test_mlw();
      test_mem_path();
      test_backpressure();
      test_overflow();
      test_back_to_back_full();
      test_rd0_and_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_result_collector.md
Name: mem_result_collector

Overview:
- Downstream stage of the memristor memory controller / virtual memristor array pair.
- Captures the registered array result one cycle after a read/gate step is issued. Routes it one of two ways:
  - back to the controller as buffer data, for gate-to-memory ops (MORM..MXNORM);
  - into a small tagged FIFO toward CPU register writeback, for MLW and register-destination gates (MOR..MXNOR).
- Generates backpressure toward the controller/pipeline.

Parameters:
- DEPTH, 4, writeback FIFO entries (power of two, >=2)
- PTR_W, 2, log2(DEPTH)
- DATA_W, 32, result width; must match array word width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  controller is driving a read/gate step to the array this cycle
- issue_opcode  in  7  opcode of the instruction held in the controller (shared opcode defines)
- issue_rd  in  5  destination field [11:7] of that instruction
- issue_step  in  1  controller second-step flag (1 = memory write-back step of an M-suffix op)
- mem_data  in  DATA_W  registered result output of the virtual memristor array
- buffer_data  out  DATA_W  to controller in_buffer_data
- wb_valid  out  1  FIFO head valid toward CPU writeback
- wb_rd  out  5  head destination register
- wb_data  out  DATA_W  head result
- wb_ready  in  1  CPU writeback accepts head this cycle
- stall_req  out  1  hold controller/pipeline issue
- overflow_err  out  1  sticky: push attempted while full without pop

Behaviour:
- Classification, combinational on issue_opcode:
  - CPU class: MLW, or MOR..MXNOR.
  - MEM class: MORM..MXNORM.
  - Anything else, or issue_step=1: no capture.
- Stage 1 (tag register):
  - Each posedge: s1_valid <= issue_valid & (CPU|MEM) & !issue_step; s1_class and s1_rd latch alongside.
  - Issue in cycle N means mem_data is valid in cycle N+1, while s1_valid=1.
- MEM path:
  - buffer_data = mem_data when s1_valid & s1_class==MEM, else buf_reg. This mux is combinational so the controller sees the result in its step-1 cycle (N+1).
  - buf_reg <= mem_data at the end of such a cycle; it holds otherwise.
  - MEM results are never pushed to the FIFO.
- CPU path:
  - At the end of cycle N+1, push {s1_rd, mem_data} if s1_valid & s1_class==CPU & s1_rd!=0.
  - rd=0 results are discarded silently.
- FIFO:
  - Circular buffer with wr_ptr, rd_ptr (PTR_W bits, wrap naturally) and count (PTR_W+1 bits).
  - Pop occurs when wb_valid & wb_ready.
  - wb_valid = (count!=0). wb_rd/wb_data are the head entry, registered storage, no bypass.
  - Earliest wb_valid is cycle N+2.
  - Push while empty with wb_ready=1: the entry appears next cycle and is popped only once wb_valid is seen.
  - Simultaneous push+pop: count unchanged, both pointers advance. This is legal even at count==DEPTH.
  - Push at count==DEPTH without pop: entry dropped, pointers unchanged, overflow_err <= 1. overflow_err clears only on rst.
  - Pop with count==0 is ignored.
- Backpressure:
  - stall_req = (count + (s1_valid & s1_class==CPU)) >= DEPTH-1. This is combinational.
  - It guarantees room for one in-flight capture plus the one being issued.
  - Provided the controller honours stall_req, overflow never occurs.
- Reset (any cycle, including mid-operation):
  - s1_valid=0, buf_reg=0, pointers=0, count=0, overflow_err=0.
  - FIFO storage contents are don't-care.
- Output values at reset: buffer_data=0, wb_valid=0, stall_req=0, overflow_err=0. wb_rd/wb_data are don't-care while wb_valid=0; the bench may not check them.
- An in-flight capture at reset is lost: its mem_data is not pushed the following cycle.

Test Plan:
- MLW with rd=5: issue cycle N, mem_data=0xDEADBEEF at N+1, wb_ready=1 → wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF at N+2; wb_valid=0 at N+3.
- MANDM step0 at N, mem_data=0x0000F0F0 at N+1 → buffer_data=0x0000F0F0 in N+1 and afterwards. Step1 issue (issue_step=1) at N+1 → no capture, FIFO count stays 0.
- wb_ready=0 with four MOR results, rd=1..4 and data 0x11,0x22,0x33,0x44:
  - stall_req rises once count+inflight reaches 3.
  - Releasing wb_ready then drains in order 1/0x11 .. 4/0x44.
  - overflow_err stays 0.
- Force five pushes while ignoring stall_req, wb_ready=0 → 5th dropped, overflow_err=1, head still rd=1.
- Count=DEPTH with simultaneous push (rd=7, 0x77) and pop → count stays 4; the last entry drained is 7/0x77.
- MXOR with rd=0 → no wb_valid. Assert rst in the cycle after any issue → next cycle wb_valid=0, buffer_data=0, no late push.
